reg_to_apb: RTL and testbench

//  Register-bus (REG_BUS-style) responder that issues each request as an APB4 requester transfer.

---
 rtl/reg_to_apb.sv | 119 +++++++++++
 tb/tb_reg_to_apb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_apb.sv
`timescale 1ns/1ps
// reg_to_apb: register-bus responder driving an APB4 requester.
// One transfer at a time: SETUP, ACCESS, then a one-cycle response.
module reg_to_apb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i,
  input  logic                  reg_write_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  input  logic [STRB_WIDTH-1:0] reg_wstrb_i,
  input  logic                  reg_valid_i,
  output logic [DATA_WIDTH-1:0] reg_rdata_o,
  output logic                  reg_error_o,
  output logic                  reg_ready_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam bit WDOG = TIMEOUT_CYCLES > 0;
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST_I = WDOG ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CW-1:0]         cnt;
  logic                  timeout;

  // cnt holds the number of ACCESS cycles already spent without pready
  assign timeout = WDOG && (cnt == LAST);

  // Transfer sequencing, request capture, response capture, watchdog
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reg_valid_i) begin
            addr_q  <= reg_addr_i;
            write_q <= reg_write_i;
            wdata_q <= reg_wdata_i;
            strb_q  <= reg_wstrb_i;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rdata_q <= write_q ? '0 : prdata_i;
            err_q   <= pslverr_i;
            state   <= RESP;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign psel_o      = (state == SETUP) || (state == ACCESS);
  assign penable_o   = (state == ACCESS);
  assign pprot_o     = 3'b000;
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = write_q ? strb_q : '0;

  assign reg_ready_o = (state == RESP);
  assign reg_rdata_o = reg_ready_o ? rdata_q : '0;
  assign reg_error_o = reg_ready_o & err_q;

endmodule

// File: tb/tb_reg_to_apb.sv
`timescale 1ns/1ps
// tb_reg_to_apb: directed and randomized checks of the APB bridge
// against a request-level memory model with a simple APB slave.
module tb_reg_to_apb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] reg_addr_i;
  logic        reg_write_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_valid_i;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        reg_ready_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_to_apb #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .reg_addr_i(reg_addr_i),
    .reg_write_i(reg_write_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i),
    .reg_valid_i(reg_valid_i),
    .reg_rdata_o(reg_rdata_o),
    .reg_error_o(reg_error_o),
    .reg_ready_o(reg_ready_o),
    .paddr_o(paddr_o),
    .pprot_o(pprot_o),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o),
    .prdata_i(prdata_i),
    .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  // APB slave: 64-word memory, programmable wait states/error/hang
  int          slv_waits = 0;
  bit          slv_err = 1'b0;
  bit          slv_hang = 1'b0;
  int          acc = 0;
  logic        noise = 1'b0;
  logic [31:0] junk = 32'h0;
  logic [31:0] prdata_q = 32'h0;
  logic [31:0] slv_mem [0:63];
  bit          mem_init = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  assign pready_i = psel_o && penable_o && !slv_hang &&
                    (acc >= slv_waits);
  assign pslverr_i = pready_i ? slv_err : noise;
  assign prdata_i  = pready_i ? prdata_q : junk;

  // slave wait-state count, noise, read data and write commit
  always @(posedge clk) begin
    acc      <= (psel_o && penable_o && !pready_i) ? acc + 1 : 0;
    noise    <= 1'($urandom);
    junk     <= $urandom;
    prdata_q <= slv_mem[paddr_o[7:2]];
    if (!mem_init) begin
      for (int i = 0; i < 64; i++)
        slv_mem[i] <= (i == 1) ? 32'hCAFE0001 : (32'hA5000000 | 32'(i));
      mem_init <= 1'b1;
    end else if (pready_i && pwrite_o && !pslverr_i) begin
      slv_mem[paddr_o[7:2]] <=
        merge(slv_mem[paddr_o[7:2]], pwdata_o, pstrb_o);
    end
  end

  // request-level reference: memory image as seen by the requester
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'hA5000000 | {26'd0, a[7:2]};
  endfunction

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input int waits, input bit err, input bit hang,
                      input bit hold, input string tag);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          lat;
    exp_lat = hang ? 2 + TMO : 3 + waits;
    exp_err = hang || err;
    exp_rd  = (w || hang) ? 32'h0 : ref_rd(a);
    if (w && !hang && !err) ref_mem[a] = merge(ref_rd(a), d, s);
    slv_waits   = waits;
    slv_err     = err;
    slv_hang    = hang;
    reg_addr_i  = a;
    reg_write_i = w;
    reg_wdata_i = d;
    reg_wstrb_i = s;
    reg_valid_i = 1'b1;
    checks++;
    if (psel_o !== 1'b0 || reg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: psel=%b ready=%b want 0 0",
               tag, psel_o, reg_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({psel_o, penable_o, pwrite_o} !== {2'b10, w} ||
        paddr_o !== a || pstrb_o !== (w ? s : 4'h0) ||
        pprot_o !== 3'b000) begin
      errors++;
      $display("FAIL %s setup: sel/en/wr=%b%b%b addr=%h strb=%h want 10%b %h %h",
               tag, psel_o, penable_o, pwrite_o, paddr_o, pstrb_o,
               w, a, (w ? s : 4'h0));
    end
    if (w) begin
      checks++;
      if (pwdata_o !== d) begin
        errors++;
        $display("FAIL %s pwdata: got %h want %h", tag, pwdata_o, d);
      end
    end
    @(posedge clk); #1;
    lat = 2;
    while (reg_ready_o !== 1'b1 && lat < 40) begin
      checks++;
      if (psel_o !== 1'b1 || penable_o !== 1'b1 || paddr_o !== a ||
          pwrite_o !== w || reg_rdata_o !== 32'h0 ||
          reg_error_o !== 1'b0) begin
        errors++;
        $display("FAIL %s access c%0d: sel=%b en=%b addr=%h rd=%h er=%b want 1 1 %h 0 0",
                 tag, lat, psel_o, penable_o, paddr_o, reg_rdata_o,
                 reg_error_o, a);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (reg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: none within %0d cycles", tag, lat);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (reg_rdata_o !== exp_rd || reg_error_o !== exp_err ||
        psel_o !== 1'b0 || penable_o !== 1'b0) begin
      errors++;
      $display("FAIL %s resp: rd=%h er=%b sel=%b en=%b want %h %b 0 0",
               tag, reg_rdata_o, reg_error_o, psel_o, penable_o,
               exp_rd, exp_err);
    end
    if (!hold) reg_valid_i = 1'b0;
    slv_hang = 1'b0;
    @(posedge clk); #1;
    reg_valid_i = 1'b0;
    checks++;
    if (reg_ready_o !== 1'b0 || psel_o !== 1'b0 ||
        reg_rdata_o !== 32'h0 || reg_error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s post: ready=%b sel=%b rd=%h er=%b want all 0",
               tag, reg_ready_o, psel_o, reg_rdata_o, reg_error_o);
    end
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    reg_addr_i  = 32'h0;
    reg_write_i = 1'b0;
    reg_wdata_i = 32'h0;
    reg_wstrb_i = 4'h0;
    reg_valid_i = 1'b0;
    ref_mem[32'h2004] = 32'hCAFE0001;
    #1;
    checks++;
    if ({psel_o, penable_o, pwrite_o, reg_ready_o, reg_error_o} !== 5'b0 ||
        paddr_o !== 32'h0 || pwdata_o !== 32'h0 || pstrb_o !== 4'h0 ||
        pprot_o !== 3'b000 || reg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: sel=%b en=%b rdy=%b addr=%h want all 0",
               psel_o, penable_o, reg_ready_o, paddr_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_write_basic();
    xfer(32'h1000, 1'b1, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 1'b0, 1'b0,
         "wr_basic");
    xfer(32'h1000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, "wr_readback");
  endtask

  task automatic test_read_wait();
    xfer(32'h2004, 1'b0, 32'h0, 4'hF, 3, 1'b0, 1'b0, 1'b0, "rd_wait3");
  endtask

  task automatic test_slverr();
    xfer(32'h2008, 1'b0, 32'h0, 4'hF, 2, 1'b1, 1'b0, 1'b0, "rd_slverr");
    xfer(32'h2008, 1'b0, 32'h0, 4'hF, 1, 1'b0, 1'b0, 1'b0, "rd_after_err");
  endtask

  task automatic test_timeout();
    xfer(32'h200C, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b1, 1'b0, "rd_timeout");
    xfer(32'h200C, 1'b1, 32'h12345678, 4'hF, 0, 1'b0, 1'b1, 1'b0,
         "wr_timeout");
    xfer(32'h200C, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, "rd_after_to");
  endtask

  task automatic test_back_to_back();
    xfer(32'h2010, 1'b1, 32'h11223344, 4'hF, 0, 1'b0, 1'b0, 1'b1, "b2b_1");
    xfer(32'h2010, 1'b1, 32'hAABBCCDD, 4'b1100, 0, 1'b0, 1'b0, 1'b1,
         "b2b_2");
    xfer(32'h2010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, "b2b_rd");
  endtask

  task automatic test_reset_mid();
    slv_hang    = 1'b1;
    reg_addr_i  = 32'h2014;
    reg_write_i = 1'b1;
    reg_wdata_i = 32'h0BADF00D;
    reg_wstrb_i = 4'hF;
    reg_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid pre: sel=%b en=%b want 1 1",
               psel_o, penable_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || reg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid drop: sel=%b en=%b rdy=%b want 0 0 0",
               psel_o, penable_o, reg_ready_o);
    end
    reg_valid_i = 1'b0;
    slv_hang    = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (reg_ready_o !== 1'b0 || psel_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid hold: rdy=%b sel=%b want 0 0",
                 reg_ready_o, psel_o);
      end
    end
    rst_ni = 1'b1;
    xfer(32'h2014, 1'b0, 32'h0, 4'hF, 1, 1'b0, 1'b0, 1'b0, "rst_mid_rd");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          idx;
      logic [31:0] a;
      idx = int'($urandom_range(0, 7));
      a   = 32'h2040 + 32'(idx * 4);
      xfer(a, 1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
